wr_ingress_ctrl: RTL
====================

WR_INGRESS_CTRL -- requirements
Module: wr_ingress_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of write data.
REQ-002 SHALL have parameter PTR_WIDTH, default 3, FIFO address width; depth is 2^PTR_WIDTH.
REQ-003 SHALL have parameter AF_THRESH, default 6, fill level at or above which almost_full asserts.
REQ-004 SHALL have port wclk  input  1  write-domain clock.
REQ-005 SHALL have port wrst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  upstream data valid.
REQ-007 SHALL have port s_ready  output  1  ingress can accept, registered.
REQ-008 SHALL have port s_data  input  DATA_WIDTH  upstream data.
REQ-009 SHALL have port full  input  1  registered full flag from the write-pointer handler.
REQ-010 SHALL have port b_wptr  input  PTR_WIDTH+1  binary write pointer from the write-pointer handler.
REQ-011 SHALL have port g_rptr_sync  input  PTR_WIDTH+1  Gray read pointer, already synchronised into wclk.
REQ-012 SHALL have port w_en  output  1  write request to the pointer handler and FIFO memory.
REQ-013 SHALL have port wdata  output  DATA_WIDTH  data written to memory at b_wptr[PTR_WIDTH-1:0].
REQ-014 SHALL have port level  output  PTR_WIDTH+1  write-side fill level (only with WR_INGRESS_LEVEL_EN).
REQ-015 SHALL have port almost_full  output  1  registered, level >= AF_THRESH (only with WR_INGRESS_LEVEL_EN).

Function
REQ-016 SHALL implement a two-entry skid buffer with states EMPTY, ONE (output register valid) and TWO (output and skid registers valid).
REQ-017 SHALL define accept = s_valid & s_ready and wr = w_en, where w_en = (state != EMPTY) & !full, combinational.
REQ-018 SHALL drive wdata from the output register at all times.
REQ-019 Transitions: EMPTY: accept -> ONE, load output reg. ONE: accept & !wr -> TWO, load skid; !accept & wr -> EMPTY; accept & wr -> ONE, load output reg from s_data; otherwise hold.
REQ-020 Transitions: TWO: wr -> ONE, move skid into output reg; otherwise hold; accept cannot occur in TWO.
REQ-021 SHALL register s_ready as (next_state != TWO), so s_ready deasserts in the cycle after the second word is held.
REQ-022 SHALL preserve data order; no word SHALL be dropped or duplicated under any s_valid/full pattern.
REQ-023 Latency: a word accepted at edge N SHALL appear on wdata with w_en=1 in cycle N+1 when full=0 and no older word is pending.
REQ-024 SHALL never assert w_en while full=1; data remains held until full deasserts.
REQ-025 With full held high, SHALL accept at most two words, then hold s_ready=0.
REQ-026 Simultaneous full deassertion and new accept SHALL both take effect in the same cycle per REQ-019/020.

Reset
REQ-027 On wrst_n=0, SHALL immediately set state EMPTY, s_ready=1, output and skid registers to 0, almost_full=0; w_en SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard held words; no w_en SHALL follow reset release until a new accept.
REQ-029 s_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-030 With macro WR_INGRESS_LEVEL_EN defined, SHALL convert g_rptr_sync to binary (bit i = XOR of bits PTR_WIDTH..i), compute level = b_wptr - b_rptr_sync modulo 2^(PTR_WIDTH+1), range 0..2^PTR_WIDTH, and register almost_full.
REQ-031 Without WR_INGRESS_LEVEL_EN, ports level and almost_full SHALL be absent and no level logic SHALL be synthesised.

Verification
REQ-032 Reset then s_valid=1, s_data=0xA5, full=0 for one cycle -> next cycle w_en=1, wdata=0xA5; following cycle w_en=0.
REQ-033 Stream 0x01..0x05 back-to-back, full=0 -> w_en high 5 consecutive cycles, wdata 0x01..0x05 in order, s_ready constant 1.
REQ-034 full=1, s_valid=1 with 0x10,0x11,0x12 -> 0x10,0x11 accepted, s_ready=0, w_en=0; release full -> 0x10,0x11,0x12 written in order.
REQ-035 Reset asserted while in state TWO -> s_ready=1, w_en=0 after release; no stale data written.
REQ-036 WR_INGRESS_LEVEL_EN, PTR_WIDTH=3: b_wptr=4'b0110, g_rptr_sync=4'b0000 -> level=6, almost_full=1 next cycle; b_wptr=4'b0001, g_rptr_sync=4'b1101 (binary 9) -> level=8 (wrap-around).

Source files
------------

// File: rtl/wr_ingress_ctrl.sv
// Write-side ingress for an async FIFO: two-entry skid buffer in front of the write pointer handler.
// Optional fill level / almost_full outputs are enabled by defining WR_INGRESS_LEVEL_EN.
module wr_ingress_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PTR_WIDTH  = 3,
   parameter int unsigned AF_THRESH  = 6
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  full,
   input  logic [PTR_WIDTH:0]    b_wptr,
   input  logic [PTR_WIDTH:0]    g_rptr_sync,
   output logic                  w_en,
   output logic [DATA_WIDTH-1:0] wdata
`ifdef WR_INGRESS_LEVEL_EN
   ,
   output logic [PTR_WIDTH:0]    level,
   output logic                  almost_full
`endif
);

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  s_ready_q, s_ready_d;
   logic                  accept;
   logic                  wr;

   assign accept  = s_valid & s_ready_q;
   assign wr      = (state_q != StEmpty) & ~full;
   assign w_en    = wr;
   assign wdata   = out_q;
   assign s_ready = s_ready_q;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d = StOne;
               out_d   = s_data;
            end
         end
         StOne: begin
            if (accept && !wr) begin
               state_d = StTwo;
               skid_d  = s_data;
            end else if (!accept && wr) begin
               state_d = StEmpty;
            end else if (accept && wr) begin
               out_d = s_data;
            end
         end
         StTwo: begin
            // s_ready is low here, so only the drain path exists
            if (wr) begin
               state_d = StOne;
               out_d   = skid_q;
            end
         end
         default: state_d = StEmpty;
      endcase
      s_ready_d = (state_d != StTwo);
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q   <= StEmpty;
         out_q     <= '0;
         skid_q    <= '0;
         s_ready_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         skid_q    <= skid_d;
         s_ready_q <= s_ready_d;
      end
   end

`ifdef WR_INGRESS_LEVEL_EN
   localparam logic [PTR_WIDTH:0] AfThresh = AF_THRESH[PTR_WIDTH:0];

   logic [PTR_WIDTH:0] b_rptr_sync;
   logic               almost_full_q;

   always_comb begin
      b_rptr_sync = '0;
      for (int unsigned i = 0; i <= PTR_WIDTH; i++) begin
         b_rptr_sync[i] = ^(g_rptr_sync >> i);
      end
   end

   // Modular subtraction handles pointer wrap; result spans 0..2^PTR_WIDTH
   assign level       = b_wptr - b_rptr_sync;
   assign almost_full = almost_full_q;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         almost_full_q <= 1'b0;
      end else begin
         almost_full_q <= (level >= AfThresh);
      end
   end
`else
   // Pointers only feed the level logic; fold them away when it is disabled
   logic unused_ptrs;
   assign unused_ptrs = ^{b_wptr, g_rptr_sync};
`endif

endmodule
